// File: rtl/axi_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register slave.
// Holds the response encoding and the byte-lane merge used on register writes.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  localparam int BYTES_PER_WORD = 4;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] byte_merge(input logic [31:0]               old,
                                             input logic [31:0]               data,
                                             input logic [BYTES_PER_WORD-1:0] strb);
    logic [31:0] res;
    res = old;
    for (int i = 0; i < BYTES_PER_WORD; i++) begin
      if (strb[i]) res[8*i +: 8] = data[8*i +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/axi_lite_addr_decode.sv
// Byte address to register index decode for the AXI4-Lite register slave.
// The offset wraps modulo 2^32, so addresses below BASE_ADDR land far out of range.
module axi_lite_addr_decode
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  localparam int         IDX_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic [31:0]      addr,
  output logic             hit,
  output logic [IDX_W-1:0] index
);

  logic [31:0] off;

  assign off   = addr - BASE_ADDR;
  assign hit   = (off[1:0] == 2'b00) && ({2'b00, off[31:2]} < 32'(NUM_REGS));
  assign index = off[IDX_W+1:2];

endmodule

// File: rtl/axi_lite_reg_slave.sv
// AXI4-Lite slave exposing NUM_REGS 32-bit read/write control registers.
// Write and read channels are fully independent; every output is a flop.
module axi_lite_reg_slave
  import axi_lite_pkg::*;
#(
  parameter int          NUM_REGS  = 16,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter logic [31:0] RESET_VAL = 32'h0000_0000
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [31:0]              awaddr,
  input  logic [2:0]               awprot,
  input  logic                     awvalid,
  output logic                     awready,
  input  logic [31:0]              wdata,
  input  logic [3:0]               wstrb,
  input  logic                     wvalid,
  output logic                     wready,
  output logic [1:0]               bresp,
  output logic                     bvalid,
  input  logic                     bready,
  input  logic [31:0]              araddr,
  input  logic [2:0]               arprot,
  input  logic                     arvalid,
  output logic                     arready,
  output logic [31:0]              rdata,
  output logic [1:0]               rresp,
  output logic                     rvalid,
  input  logic                     rready,
  output logic [NUM_REGS*32-1:0]   reg_q,
  output logic [NUM_REGS-1:0]      wr_pulse
);

  localparam int IDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  // Handshake rule on every channel: a beat transfers on the rising edge where
  // valid && ready are both high; a raised valid holds its payload until then.

  logic              unused_prot;
  logic [31:0]       regs [NUM_REGS];
  logic              aw_held, w_held, aw_held_n, w_held_n, bvalid_n, rvalid_n;
  logic [31:0]       aw_addr_q, w_data_q;
  logic [3:0]        w_strb_q;
  logic              aw_hs, w_hs, b_hs, ar_hs, r_hs, commit;
  logic              wr_hit, rd_hit;
  logic [IDX_W-1:0]  wr_idx, rd_idx;

  assign unused_prot = ^{awprot, arprot};

  assign aw_hs  = awvalid && awready;
  assign w_hs   = wvalid && wready;
  assign b_hs   = bvalid && bready;
  assign ar_hs  = arvalid && arready;
  assign r_hs   = rvalid && rready;
  assign commit = aw_held && w_held;

  axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_wr_decode (
    .addr  (aw_addr_q),
    .hit   (wr_hit),
    .index (wr_idx)
  );

  axi_lite_addr_decode #(.NUM_REGS(NUM_REGS), .BASE_ADDR(BASE_ADDR)) u_rd_decode (
    .addr  (araddr),
    .hit   (rd_hit),
    .index (rd_idx)
  );

  // Commit only happens with bvalid low, since both flags need open readys to fill.
  always_comb begin
    aw_held_n = aw_held;
    w_held_n  = w_held;
    bvalid_n  = bvalid;
    if (commit) begin
      aw_held_n = 1'b0;
      w_held_n  = 1'b0;
      bvalid_n  = 1'b1;
    end else begin
      if (aw_hs) aw_held_n = 1'b1;
      if (w_hs)  w_held_n  = 1'b1;
      if (b_hs)  bvalid_n  = 1'b0;
    end
  end

  always_comb begin
    rvalid_n = rvalid;
    if (ar_hs)     rvalid_n = 1'b1;
    else if (r_hs) rvalid_n = 1'b0;
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      aw_held   <= 1'b0;
      w_held    <= 1'b0;
      awready   <= 1'b0;
      wready    <= 1'b0;
      bvalid    <= 1'b0;
      bresp     <= 2'b00;
      aw_addr_q <= '0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
    end else begin
      aw_held <= aw_held_n;
      w_held  <= w_held_n;
      bvalid  <= bvalid_n;
      awready <= !aw_held_n && !bvalid_n;
      wready  <= !w_held_n && !bvalid_n;
      if (aw_hs) aw_addr_q <= awaddr;
      if (w_hs) begin
        w_data_q <= wdata;
        w_strb_q <= wstrb;
      end
      if (commit) bresp <= wr_hit ? OKAY : SLVERR;
    end
  end

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= RESET_VAL;
      wr_pulse <= '0;
    end else begin
      wr_pulse <= '0;
      if (commit && wr_hit) begin
        regs[wr_idx]     <= byte_merge(regs[wr_idx], w_data_q, w_strb_q);
        wr_pulse[wr_idx] <= 1'b1;
      end
    end
  end

  // Read data is sampled at the AR edge, so a coincident commit is not visible yet.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      rvalid  <= 1'b0;
      arready <= 1'b0;
      rdata   <= '0;
      rresp   <= 2'b00;
    end else begin
      rvalid  <= rvalid_n;
      arready <= !rvalid_n;
      if (ar_hs) begin
        rdata <= rd_hit ? regs[rd_idx] : '0;
        rresp <= rd_hit ? OKAY : SLVERR;
      end
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_reg_q
    assign reg_q[32*i +: 32] = regs[i];
  end

endmodule

// File: tb/tb_axi_lite_reg_slave.sv
// Directed bench for axi_lite_reg_slave: a vector table of single transactions
// plus hand-timed sequences for backpressure, read/commit collision and reset.
module tb_axi_lite_reg_slave;

  localparam int          NREGS = 16;
  localparam logic [31:0] BASE  = 32'h0000_0100;

  logic              aclk;
  logic              aresetn;
  logic [31:0]       awaddr;
  logic [2:0]        awprot;
  logic              awvalid;
  logic              awready;
  logic [31:0]       wdata;
  logic [3:0]        wstrb;
  logic              wvalid;
  logic              wready;
  logic [1:0]        bresp;
  logic              bvalid;
  logic              bready;
  logic [31:0]       araddr;
  logic [2:0]        arprot;
  logic              arvalid;
  logic              arready;
  logic [31:0]       rdata;
  logic [1:0]        rresp;
  logic              rvalid;
  logic              rready;
  logic [NREGS*32-1:0] reg_q;
  logic [NREGS-1:0]  wr_pulse;

  axi_lite_reg_slave #(.NUM_REGS(NREGS), .BASE_ADDR(BASE), .RESET_VAL(32'h0)) dut (
    .aclk     (aclk),
    .aresetn  (aresetn),
    .awaddr   (awaddr),
    .awprot   (awprot),
    .awvalid  (awvalid),
    .awready  (awready),
    .wdata    (wdata),
    .wstrb    (wstrb),
    .wvalid   (wvalid),
    .wready   (wready),
    .bresp    (bresp),
    .bvalid   (bvalid),
    .bready   (bready),
    .araddr   (araddr),
    .arprot   (arprot),
    .arvalid  (arvalid),
    .arready  (arready),
    .rdata    (rdata),
    .rresp    (rresp),
    .rvalid   (rvalid),
    .rready   (rready),
    .reg_q    (reg_q),
    .wr_pulse (wr_pulse)
  );

  // clock / reset
  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int total;
  int bad;
  logic [31:0] model [NREGS];

  typedef struct {
    bit          is_wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [1:0]  resp;
    logic [31:0] rdata;
    logic [15:0] pulse;
  } vec_t;

  vec_t vecs [18];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge aclk);
  endtask

  function automatic logic [31:0] reg_of(input int i);
    return reg_q[32*i +: 32];
  endfunction

  function automatic logic [31:0] merge_model(input logic [31:0] old, input logic [31:0] d,
                                              input logic [3:0] s);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return (old & ~m) | (d & m);
  endfunction

  task automatic chk_all_regs(input string name);
    for (int i = 0; i < NREGS; i++) chk($sformatf("%s_reg%0d", name, i), reg_of(i), model[i]);
  endtask

  // driver tasks: called at a negedge, return at a negedge
  task automatic write_txn(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb,
                           output logic [1:0] resp, output logic [15:0] pulse_or,
                           output int pulse_cnt, output bit timed_out);
    bit aw_go, w_go;
    int cyc;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = 1'b1;
    pulse_or = '0; pulse_cnt = 0; timed_out = 1'b0; resp = 2'b00; cyc = 0;
    while ((awvalid || wvalid) && cyc < 20) begin
      aw_go = awvalid && awready;
      w_go  = wvalid && wready;
      tick(); cyc++;
      if (aw_go) awvalid = 1'b0;
      if (w_go)  wvalid  = 1'b0;
      pulse_or |= wr_pulse;
      if (wr_pulse != '0) pulse_cnt++;
    end
    while (!bvalid && cyc < 20) begin
      tick(); cyc++;
      pulse_or |= wr_pulse;
      if (wr_pulse != '0) pulse_cnt++;
    end
    if (!bvalid) begin
      timed_out = 1'b1;
      awvalid = 1'b0; wvalid = 1'b0;
    end else begin
      resp = bresp;
      tick();
      pulse_or |= wr_pulse;
      if (wr_pulse != '0) pulse_cnt++;
    end
  endtask

  task automatic read_txn(input logic [31:0] addr, output logic [31:0] data,
                          output logic [1:0] resp, output bit timed_out);
    bit go;
    int cyc;
    araddr = addr; arvalid = 1'b1; rready = 1'b1;
    timed_out = 1'b0; data = '0; resp = 2'b00; cyc = 0;
    while (arvalid && cyc < 20) begin
      go = arready;
      tick(); cyc++;
      if (go) arvalid = 1'b0;
    end
    while (!rvalid && cyc < 20) begin
      tick(); cyc++;
    end
    if (!rvalid) begin
      timed_out = 1'b1;
      arvalid = 1'b0;
    end else begin
      data = rdata;
      resp = rresp;
      tick();
    end
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] data;
    logic [15:0] pulse_or;
    int          pulse_cnt;
    bit          to;
    int          idx;

    total = 0; bad = 0;
    aresetn = 1'b0;
    awaddr = '0; awprot = 3'b000; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wvalid = 1'b0; bready = 1'b1;
    araddr = '0; arprot = 3'b000; arvalid = 1'b0; rready = 1'b1;
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;

    // vectors: {is_wr, addr, data, strb, resp, rdata, pulse}
    vecs[0]  = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 2'b00, 32'hDEAD_BEEF, 16'h0000};
    vecs[1]  = '{1'b1, 32'h0000_0108, 32'h1122_3344, 4'h5, 2'b00, 32'h0,         16'h0004};
    vecs[2]  = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44, 16'h0000};
    vecs[3]  = '{1'b1, 32'h0000_0140, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         16'h0000};
    vecs[4]  = '{1'b1, 32'h0000_0102, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         16'h0000};
    vecs[5]  = '{1'b1, 32'h0000_00FC, 32'hFFFF_FFFF, 4'hF, 2'b10, 32'h0,         16'h0000};
    vecs[6]  = '{1'b0, 32'h0000_0141, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0000};
    vecs[7]  = '{1'b0, 32'h0000_0140, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0000};
    vecs[8]  = '{1'b0, 32'h8000_0108, 32'h0,         4'h0, 2'b10, 32'h0,         16'h0000};
    vecs[9]  = '{1'b1, 32'h0000_013C, 32'hCAFE_F00D, 4'hF, 2'b00, 32'h0,         16'h8000};
    vecs[10] = '{1'b0, 32'h0000_013C, 32'h0,         4'h0, 2'b00, 32'hCAFE_F00D, 16'h0000};
    vecs[11] = '{1'b1, 32'h0000_0100, 32'h1234_5678, 4'h0, 2'b00, 32'h0,         16'h0001};
    vecs[12] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 2'b00, 32'h0000_0000, 16'h0000};
    vecs[13] = '{1'b1, 32'h0000_0100, 32'hA1B2_C3D4, 4'hA, 2'b00, 32'h0,         16'h0001};
    vecs[14] = '{1'b0, 32'h0000_0100, 32'h0,         4'h0, 2'b00, 32'hA100_C300, 16'h0000};
    vecs[15] = '{1'b0, 32'h0000_0108, 32'h0,         4'h0, 2'b00, 32'hDE22_BE44, 16'h0000};
    vecs[16] = '{1'b1, 32'h0000_0104, 32'h0000_00FF, 4'h1, 2'b00, 32'h0,         16'h0002};
    vecs[17] = '{1'b0, 32'h0000_0104, 32'h0,         4'h0, 2'b00, 32'h0000_00FF, 16'h0000};

    // reset state
    tick(); tick();
    chk("rst_awready", awready, 0);
    chk("rst_bvalid", bvalid, 0);
    chk("rst_rvalid", rvalid, 0);
    aresetn = 1'b1;
    chk("rel_wready_low", wready, 0);
    chk("rel_arready_low", arready, 0);
    tick();
    chk("rel_awready", awready, 1);
    chk("rel_wready", wready, 1);
    chk("rel_arready", arready, 1);
    chk("rel_bvalid", bvalid, 0);
    chk("rel_rvalid", rvalid, 0);
    chk("rel_wr_pulse", wr_pulse, 0);
    chk_all_regs("rel");

    // AW first, W three cycles later, B held off for five cycles
    bready = 1'b0;
    awaddr = BASE + 32'h8; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("seqb_awready_held", awready, 0);
    for (int i = 0; i < 3; i++) begin
      chk("seqb_wready_wait", wready, 1);
      chk("seqb_bvalid_wait", bvalid, 0);
      tick();
    end
    wdata = 32'hDEAD_BEEF; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("seqb_bvalid_pending", bvalid, 0);
    chk("seqb_wready_held", wready, 0);
    tick();
    chk("seqb_bvalid", bvalid, 1);
    chk("seqb_bresp", bresp, 2'b00);
    chk("seqb_pulse", wr_pulse, 16'h0004);
    chk("seqb_reg2", reg_of(2), 32'hDEAD_BEEF);
    model[2] = 32'hDEAD_BEEF;
    for (int i = 0; i < 5; i++) begin
      tick();
      chk("bp_bvalid", bvalid, 1);
      chk("bp_bresp", bresp, 2'b00);
      chk("bp_awready", awready, 0);
      chk("bp_wready", wready, 0);
      chk("bp_pulse_gone", wr_pulse, 0);
    end
    bready = 1'b1;
    tick();
    chk("bp_bvalid_clr", bvalid, 0);
    chk("bp_awready_back", awready, 1);
    chk("bp_wready_back", wready, 1);

    // table
    for (int v = 0; v < 18; v++) begin
      if (vecs[v].is_wr) begin
        write_txn(vecs[v].addr, vecs[v].data, vecs[v].strb, resp, pulse_or, pulse_cnt, to);
        chk($sformatf("v%0d_wr_timeout", v), 32'(to), 0);
        chk($sformatf("v%0d_bresp", v), resp, vecs[v].resp);
        chk($sformatf("v%0d_pulse", v), pulse_or, vecs[v].pulse);
        chk($sformatf("v%0d_pulse_cycles", v), pulse_cnt, (vecs[v].pulse != 0) ? 1 : 0);
        if (vecs[v].pulse != 0) begin
          idx = int'((vecs[v].addr - BASE) >> 2);
          model[idx] = merge_model(model[idx], vecs[v].data, vecs[v].strb);
        end
        chk_all_regs($sformatf("v%0d", v));
      end else begin
        read_txn(vecs[v].addr, data, resp, to);
        chk($sformatf("v%0d_rd_timeout", v), 32'(to), 0);
        chk($sformatf("v%0d_rdata", v), data, vecs[v].rdata);
        chk($sformatf("v%0d_rresp", v), resp, vecs[v].resp);
      end
    end

    // read backpressure
    rready = 1'b0;
    araddr = BASE + 32'h8; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    for (int i = 0; i < 5; i++) begin
      chk("rbp_rvalid", rvalid, 1);
      chk("rbp_rdata", rdata, 32'hDE22_BE44);
      chk("rbp_rresp", rresp, 2'b00);
      chk("rbp_arready", arready, 0);
      tick();
    end
    rready = 1'b1;
    tick();
    chk("rbp_rvalid_clr", rvalid, 0);
    chk("rbp_arready_back", arready, 1);

    // AR handshake on the same edge as the reg 5 commit
    awaddr = BASE + 32'h14; awvalid = 1'b1;
    wdata = 32'hA5A5_A5A5; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    awvalid = 1'b0; wvalid = 1'b0;
    araddr = BASE + 32'h14; arvalid = 1'b1;
    tick();
    arvalid = 1'b0;
    chk("coll_bvalid", bvalid, 1);
    chk("coll_rvalid", rvalid, 1);
    chk("coll_rdata_old", rdata, 32'h0);
    chk("coll_reg5", reg_of(5), 32'hA5A5_A5A5);
    model[5] = 32'hA5A5_A5A5;
    tick();
    chk("coll_bvalid_clr", bvalid, 0);
    chk("coll_rvalid_clr", rvalid, 0);
    read_txn(BASE + 32'h14, data, resp, to);
    chk("coll_reread_timeout", 32'(to), 0);
    chk("coll_reread", data, 32'hA5A5_A5A5);

    // reset with AW held and W still pending
    awaddr = BASE + 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_awready_held", awready, 0);
    #2 aresetn = 1'b0;
    #1;
    chk("mid_rst_bvalid", bvalid, 0);
    chk("mid_rst_awready", awready, 0);
    chk("mid_rst_reg5", reg_of(5), 32'h0);
    tick(); tick();
    aresetn = 1'b1;
    tick();
    for (int i = 0; i < NREGS; i++) model[i] = 32'h0;
    chk("mid_rel_awready", awready, 1);
    chk("mid_rel_wready", wready, 1);
    chk("mid_rel_bvalid", bvalid, 0);
    chk_all_regs("mid_rel");
    wdata = 32'h0000_0077; wstrb = 4'hF; wvalid = 1'b1;
    tick();
    wvalid = 1'b0;
    chk("mid_wready_held", wready, 0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("mid_no_bvalid", bvalid, 0);
      chk("mid_reg6_kept", reg_of(6), 32'h0);
    end
    awaddr = BASE + 32'h18; awvalid = 1'b1;
    tick();
    awvalid = 1'b0;
    chk("mid_restart_pending", bvalid, 0);
    tick();
    chk("mid_restart_bvalid", bvalid, 1);
    chk("mid_restart_bresp", bresp, 2'b00);
    chk("mid_restart_reg6", reg_of(6), 32'h0000_0077);
    chk("mid_restart_pulse", wr_pulse, 16'h0040);
    tick();
    chk("mid_restart_bvalid_clr", bvalid, 0);

    // final report
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
